// File: rtl/key_led_ctrl_if.sv
// key_led_ctrl_if: key event inputs and LED/mode outputs of key_led_ctrl.
//   key_flag0/1  : one-cycle debounced-edge pulses from the key debouncers
//   key_state0/1 : debounced key levels, 0 = pressed
//   led          : 4-bit LED drive, 1 = on
//   mode         : current mode (00 IDLE, 01 COUNT, 10 RUN, 11 BLINK)
// The slave modport is the controller; the master modport is whoever drives the keys.
interface key_led_ctrl_if;
  logic       key_flag0;
  logic       key_state0;
  logic       key_flag1;
  logic       key_state1;
  logic [3:0] led;
  logic [1:0] mode;

  modport slave (
    input  key_flag0, key_state0, key_flag1, key_state1,
    output led, mode
  );

  modport master (
    output key_flag0, key_state0, key_flag1, key_state1,
    input  led, mode
  );
endinterface

// File: rtl/key_led_ctrl.sv
// key_led_ctrl: 4-mode key controller and LED pattern scheduler.
//   Clk   : system clock, rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : key_led_ctrl_if.slave (key flags/levels in, led/mode out)
// key1 presses step the mode IDLE->COUNT->RUN->BLINK->IDLE; key0 presses act
// within the mode. An internal prescaler produces the RUN/BLINK pattern ticks.
module key_led_ctrl #(
  parameter int TICK_CNT  = 25_000_000,
  parameter int TICK_FAST = 6_250_000
) (
  input  logic           Clk,
  input  logic           Rst_n,
  key_led_ctrl_if.slave  bus
);

  localparam int PW = (TICK_CNT > 2) ? $clog2(TICK_CNT) : 1;
  localparam logic [PW-1:0] LIM_SLOW = PW'(TICK_CNT - 1);
  localparam logic [PW-1:0] LIM_FAST = PW'(TICK_FAST - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, COUNT = 2'b01, RUN = 2'b10, BLINK = 2'b11} mode_t;

  mode_t         mode_q, mode_n;
  logic [3:0]    led_q, led_n;
  logic [3:0]    cnt_q, cnt_n;
  logic          dir_q, dir_n;   // 0 = left, 1 = right
  logic          spd_q, spd_n;   // 0 = slow, 1 = fast
  logic          ph_q,  ph_n;
  logic [PW-1:0] psc_q, psc_n;

  logic          p0, p1, tick;
  logic [PW-1:0] lim;

  // Only press edges count; release flags arrive with state = 1.
  assign p0 = bus.key_flag0 & ~bus.key_state0;
  assign p1 = bus.key_flag1 & ~bus.key_state1;

  assign bus.led  = led_q;
  assign bus.mode = mode_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mode_q <= IDLE;
      led_q  <= 4'b0000;
      cnt_q  <= 4'd0;
      dir_q  <= 1'b0;
      spd_q  <= 1'b0;
      ph_q   <= 1'b0;
      psc_q  <= '0;
    end else begin
      mode_q <= mode_n;
      led_q  <= led_n;
      cnt_q  <= cnt_n;
      dir_q  <= dir_n;
      spd_q  <= spd_n;
      ph_q   <= ph_n;
      psc_q  <= psc_n;
    end
  end

  always_comb begin
    mode_n = mode_q;
    led_n  = led_q;
    cnt_n  = cnt_q;
    dir_n  = dir_q;
    spd_n  = spd_q;
    ph_n   = ph_q;
    psc_n  = psc_q;
    lim    = (mode_q == BLINK && spd_q) ? LIM_FAST : LIM_SLOW;
    tick   = (mode_q == RUN || mode_q == BLINK) && (psc_q == lim);

    if (p1) begin
      // Mode change wins over any same-cycle key0 press; cnt is retained.
      psc_n = '0;
      dir_n = 1'b0;
      spd_n = 1'b0;
      ph_n  = 1'b0;
      unique case (mode_q)
        IDLE:    begin mode_n = COUNT; led_n = cnt_q;   end
        COUNT:   begin mode_n = RUN;   led_n = 4'b0001; end
        RUN:     begin mode_n = BLINK; led_n = 4'b0000; end
        default: begin mode_n = IDLE;  led_n = 4'b0000; end
      endcase
    end else begin
      unique case (mode_q)
        IDLE: begin
          led_n = 4'b0000;
          psc_n = '0;
        end
        COUNT: begin
          psc_n = '0;
          if (p0) cnt_n = cnt_q + 4'd1;
          led_n = cnt_n;
        end
        RUN: begin
          psc_n = tick ? '0 : psc_q + 1'b1;
          if (p0) dir_n = ~dir_q;
          // A coincident key0 press already steers this rotation.
          if (tick) led_n = dir_n ? {led_q[0], led_q[3:1]} : {led_q[2:0], led_q[3]};
        end
        default: begin
          // A speed change restarts the period and suppresses a coincident tick.
          if (p0) begin
            spd_n = ~spd_q;
            psc_n = '0;
          end else begin
            psc_n = tick ? '0 : psc_q + 1'b1;
            if (tick) begin
              ph_n  = ~ph_q;
              led_n = {4{~ph_q}};
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_led_ctrl.sv
module tb_key_led_ctrl;
  logic Clk = 1'b0;
  logic Rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  key_led_ctrl_if bus ();

  key_led_ctrl #(.TICK_CNT(10), .TICK_FAST(4)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive flags at a negedge, hold through one posedge, return at the next negedge.
  task automatic press(input logic f0, input logic f1);
    bus.key_flag0  = f0;
    bus.key_state0 = ~f0;
    bus.key_flag1  = f1;
    bus.key_state1 = ~f1;
    @(negedge Clk);
    bus.key_flag0  = 1'b0;
    bus.key_state0 = 1'b1;
    bus.key_flag1  = 1'b0;
    bus.key_state1 = 1'b1;
  endtask

  // led holds 'hold' for pre cycles, then shows 'nxt' on the following one.
  task automatic step(input string tag, input int pre, input logic [3:0] hold, input logic [3:0] nxt);
    repeat (pre) @(negedge Clk);
    chk({tag, "_hold"}, {4'h0, bus.led}, {4'h0, hold});
    @(negedge Clk);
    chk({tag, "_step"}, {4'h0, bus.led}, {4'h0, nxt});
  endtask

  initial begin
    bus.key_flag0 = 1'b0; bus.key_state0 = 1'b1;
    bus.key_flag1 = 1'b0; bus.key_state1 = 1'b1;
    Rst_n = 1'b0;
    repeat (10) @(negedge Clk);
    chk("rst_mode", {6'h0, bus.mode}, 8'h00);
    chk("rst_led",  {4'h0, bus.led},  8'h00);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Release flag on key1 is ignored.
    bus.key_flag1 = 1'b1; bus.key_state1 = 1'b1;
    @(negedge Clk);
    bus.key_flag1 = 1'b0;
    chk("rel_ignored", {6'h0, bus.mode}, 8'h00);

    // Mode stepping, then COUNT with 17 key0 presses.
    press(0, 1);
    chk("to_count", {6'h0, bus.mode}, 8'h01);
    chk("count_led0", {4'h0, bus.led}, 8'h00);
    for (int i = 1; i <= 17; i++) begin
      press(1, 0);
      chk($sformatf("count_%0d", i), {4'h0, bus.led}, 8'(i % 16));
    end
    press(0, 1);
    chk("to_run", {6'h0, bus.mode}, 8'h02);
    chk("run_entry", {4'h0, bus.led}, 8'h01);
    press(0, 1);
    chk("to_blink", {6'h0, bus.mode}, 8'h03);
    chk("blink_entry", {4'h0, bus.led}, 8'h00);
    press(0, 1);
    chk("to_idle", {6'h0, bus.mode}, 8'h00);
    press(1, 0);
    chk("idle_p0", {4'h0, bus.led}, 8'h00);
    press(0, 1);
    chk("cnt_retained", {4'h0, bus.led}, 8'h01);

    // cnt=3, then simultaneous presses: key1 wins.
    press(1, 0);
    press(1, 0);
    chk("cnt3", {4'h0, bus.led}, 8'h03);
    press(1, 1);
    chk("both_mode", {6'h0, bus.mode}, 8'h02);
    chk("both_led",  {4'h0, bus.led},  8'h01);
    press(0, 1); press(0, 1); press(0, 1);
    chk("both_cnt_kept", {4'h0, bus.led}, 8'h03);

    // RUN rotation with TICK_CNT=10, then direction change.
    press(0, 1);
    chk("run_mode", {6'h0, bus.mode}, 8'h02);
    step("run1", 9, 4'b0001, 4'b0010);
    step("run2", 9, 4'b0010, 4'b0100);
    step("run3", 9, 4'b0100, 4'b1000);
    step("run4", 9, 4'b1000, 4'b0001);
    press(1, 0);
    chk("run_p0_nomove", {4'h0, bus.led}, 8'h01);
    step("runr1", 8, 4'b0001, 4'b1000);
    step("runr2", 9, 4'b1000, 4'b0100);

    // BLINK slow then fast.
    press(0, 1);
    chk("blink_mode", {6'h0, bus.mode}, 8'h03);
    step("blk1", 9, 4'b0000, 4'b1111);
    step("blk2", 9, 4'b1111, 4'b0000);
    press(1, 0);
    chk("blk_p0_hold", {4'h0, bus.led}, 8'h00);
    step("blkf1", 3, 4'b0000, 4'b1111);
    step("blkf2", 3, 4'b1111, 4'b0000);

    // Asynchronous reset in RUN with led=0100.
    press(0, 1); press(0, 1); press(0, 1);
    chk("run_again", {6'h0, bus.mode}, 8'h02);
    step("arun1", 9, 4'b0001, 4'b0010);
    step("arun2", 9, 4'b0010, 4'b0100);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_led",  {4'h0, bus.led},  8'h00);
    chk("arst_mode", {6'h0, bus.mode}, 8'h00);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("post_rst_mode", {6'h0, bus.mode}, 8'h00);
    press(0, 1);
    chk("post_rst_count", {6'h0, bus.mode}, 8'h01);
    chk("post_rst_cnt",   {4'h0, bus.led},  8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/key_led_ctrl.md
Name: key_led_ctrl

Overview:
Mode controller and pattern scheduler between the two key debounce units and the 4-bit LED bank. It converts debounced press events into a 4-mode state machine: key1 selects the mode and key0 acts within it. It also sequences the LED outputs from an internal tick prescaler. It sits inside key_led_top, replacing ad-hoc LED logic.

Parameters:
TICK_CNT, 25_000_000, Clk cycles per slow tick (500 ms at 50 MHz); must be >= 2
TICK_FAST, 6_250_000, Clk cycles per fast tick (BLINK fast speed only); must be >= 2 and < TICK_CNT

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
key_flag0  input  1  one-cycle pulse from key0 debounce on any debounced edge
key_state0  input  1  key0 debounced level; 0 = pressed
key_flag1  input  1  one-cycle pulse from key1 debounce
key_state1  input  1  key1 debounced level; 0 = pressed
led  output  4  LED drive, registered, 1 = on
mode  output  2  current mode, registered: 00 IDLE, 01 COUNT, 10 RUN, 11 BLINK

Behaviour:
- Clocking and reset: one clock domain (Clk). Rst_n is asynchronous, active-low.
- Press events: p0 = key_flag0 & ~key_state0; p1 = key_flag1 & ~key_state1. Release edges (flag with state=1) are ignored.
- Reset values (all registers):
  - mode=00, led=0000, cnt=0 (4-bit), run pattern=0001, dir=left, speed=slow, blink phase=0, prescaler=0.
- Latency: every output change takes effect on the same Clk edge that samples the event or tick. The outputs are registered, so there is one cycle of latency from a flag.
- Mode FSM:
  - p1 advances the mode: IDLE->COUNT->RUN->BLINK->IDLE.
  - Entry actions on each mode change:
    - clear the prescaler to 0;
    - set run pattern=0001 and dir=left;
    - set blink phase=0 and speed=slow;
    - cnt is retained.
  - Simultaneous p0 and p1 in the same cycle: p1 wins and p0 is dropped.
- Prescaler: counts 0..LIM-1 and emits a one-cycle tick when it equals LIM-1, then wraps to 0.
  - LIM = TICK_FAST in BLINK with speed=fast; otherwise LIM = TICK_CNT.
  - A speed change clears the prescaler.
  - The prescaler runs only in RUN and BLINK; it is held at 0 in IDLE and COUNT.
- IDLE: led=0000. p0 is ignored.
- COUNT:
  - led = cnt, and entering COUNT shows the retained cnt immediately.
  - p0: cnt=cnt+1, modulo 16 (15 wraps to 0).
- RUN:
  - On entry led=0001.
  - On each tick: left rotates led={led[2:0],led[3]}; right rotates led={led[0],led[3:1]}.
  - p0 toggles dir, effective from the next tick. The pattern does not move on the p0 cycle.
  - If p0 and a tick coincide, the rotation uses the new dir.
- BLINK:
  - On entry led=0000.
  - Each tick toggles phase: phase 1 gives led=1111, phase 0 gives led=0000.
  - p0 toggles speed and clears the prescaler. led and phase are unchanged on that cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Operation resumes on the first Clk edge with Rst_n high.
- No event queuing: a press arriving while another is processed is impossible, because each press is a single-cycle flag handled that cycle.

Test Plan:
1. Reset hold 10 cycles, then release; pulse key_flag1 with key_state1=0 three times -> mode goes 01, 10, 11 on the edge after each flag. A release flag (key_state1=1) causes no change.
2. COUNT mode, 17 key0 presses -> led steps 0001..1111, 0000, 0001. Exit to RUN and cycle back through BLINK and IDLE to COUNT -> led=0001 shown on entry (cnt retained).
3. TICK_CNT=10, RUN mode -> led 0001 held 10 cycles, then 0010, 0100, 1000, 0001 every 10 cycles. After a key0 press, the next ticks give 1000, 0100.
4. TICK_CNT=10, TICK_FAST=4, BLINK mode -> 1111 at cycle 10, 0000 at cycle 20. After a key0 press, the prescaler clears and the period becomes 4: toggle 4 cycles after the press, then every 4 cycles.
5. key_flag0 and key_flag1 pulsed in the same cycle while in COUNT with cnt=3 -> mode=10, led=0001, cnt stays 3 (p0 dropped).
6. Assert Rst_n low asynchronously (between Clk edges) in RUN with led=0100 -> led=0000 and mode=00 immediately, without waiting for a Clk edge.
